// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit data-memory master.
// Access sizes, FSM states and the byte-count helper.
package lsu_pkg;

  localparam int DMEM_AW = 16;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_RSV
  } lsu_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1
  } lsu_state_e;

  function automatic logic [2:0] size_nbytes(lsu_size_e s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store masks/data over two words,
// and load extraction from a two-word window with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  lsu_size_e   i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [7:0]  o_bmask,
  output logic [63:0] o_sdata,
  output logic        o_split,
  input  logic [1:0]  i_ld_off,
  input  lsu_size_e   i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [55:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [2:0]  nb;
  logic [3:0]  nmask;
  logic [31:0] shr;

  always_comb begin
    nb      = size_nbytes(i_st_size);
    nmask   = 4'((5'd1 << nb) - 5'd1);
    o_bmask = {4'b0000, nmask} << i_st_off;
    o_sdata = {32'b0, i_st_wdata} << {i_st_off, 3'b000};
    o_split = ({1'b0, i_st_off} + nb) > 3'd4;
  end

  // A split access never needs bytes beyond offset 3 + 4 = 7.
  always_comb begin
    shr = i_ld_raw[{i_ld_off, 3'b000} +: 32];
    case (i_ld_size)
      SZ_B: begin
        if (i_ld_unsigned) o_ld_data = {24'b0, shr[7:0]};
        else               o_ld_data = {{24{shr[7]}}, shr[7:0]};
      end
      SZ_H: begin
        if (i_ld_unsigned) o_ld_data = {16'b0, shr[15:0]};
        else               o_ld_data = {{16{shr[15]}}, shr[15:0]};
      end
      SZ_W:    o_ld_data = shr;
      default: o_ld_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator for the 64 KiB data memory; one request
// in flight, misaligned accesses split into two word accesses.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] P_BASE     = 32'h0001_0000,
  parameter bit          P_SPLIT_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [31:0]        i_req_addr,
  input  logic               i_req_we,
  input  logic [1:0]         i_req_size,
  input  logic               i_req_unsigned,
  input  logic [31:0]        i_req_wdata,
  output logic               o_rsp_valid,
  output logic [31:0]        o_rsp_rdata,
  output logic               o_rsp_err,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [31:0]        o_dmem_wdata,
  output logic [3:0]         o_dmem_wren,
  input  logic [31:0]        i_dmem_q
);

  lsu_state_e state_q, state_d;
  lsu_size_e  size_q, size_d;
  logic [1:0] off_q, off_d;
  logic       uns_q, uns_d;
  logic       we_q, we_d;
  logic       err_q, err_d;
  logic       split_q, split_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] whi_q, whi_d;
  logic [3:0]  bhi_q, bhi_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wren_q, wren_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  lsu_size_e   req_size;
  logic [7:0]  bmask;
  logic [63:0] sdata;
  logic        st_split;
  logic        req_err;
  logic [55:0] ld_raw;
  logic [31:0] ld_data;

  assign req_size = lsu_size_e'(i_req_size);
  assign ld_raw = (state_q == S_ACC1) ? {i_dmem_q[23:0], lo_q}
                                      : {24'b0, i_dmem_q};

  lsu_align u_align (
    .i_st_off      (i_req_addr[1:0]),
    .i_st_size     (req_size),
    .i_st_wdata    (i_req_wdata),
    .o_bmask       (bmask),
    .o_sdata       (sdata),
    .o_split       (st_split),
    .i_ld_off      (off_q),
    .i_ld_size     (size_q),
    .i_ld_unsigned (uns_q),
    .i_ld_raw      (ld_raw),
    .o_ld_data     (ld_data)
  );

  // All error causes are known at accept, so no write is ever issued for them.
  assign req_err = (i_req_addr[31:16] != P_BASE[31:16])
                 | (req_size == SZ_RSV)
                 | (st_split & (!P_SPLIT_EN
                 | (i_req_addr[15:2] == 14'h3FFF)));

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    we_d        = we_q;
    err_d       = err_q;
    split_d     = split_q;
    lo_d        = lo_q;
    whi_d       = whi_q;
    bhi_d       = bhi_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wren_d      = 4'b0000;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = S_ACC0;
          size_d  = req_size;
          off_d   = i_req_addr[1:0];
          uns_d   = i_req_unsigned;
          we_d    = i_req_we;
          err_d   = req_err;
          split_d = st_split;
          whi_d   = sdata[63:32];
          bhi_d   = bmask[7:4];
          addr_d  = {i_req_addr[15:2], 2'b00};
          wdata_d = sdata[31:0];
          if (i_req_we && !req_err) wren_d = bmask[3:0];
        end
      end
      S_ACC0: begin
        if (split_q && !err_q) begin
          state_d = S_ACC1;
          lo_d    = i_dmem_q;
          addr_d  = addr_q + 16'd4;
          wdata_d = whi_q;
          if (we_q) wren_d = bhi_q;
        end else begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (err_q || we_q) ? 32'b0 : ld_data;
        end
      end
      S_ACC1: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'b0 : ld_data;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_B;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= 32'b0;
      whi_q       <= 32'b0;
      bhi_q       <= 4'b0000;
      addr_q      <= '0;
      wdata_q     <= 32'b0;
      wren_q      <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      err_q       <= err_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      whi_q       <= whi_d;
      bhi_q       <= bhi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_rdata  = rsp_rdata_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wren  = wren_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed vectors, byte-level reference
// model with random traffic, back-to-back stream and mid-split reset.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wren;
  logic [31:0] dm_q;
  logic        mem_clr;

  logic [31:0] mem [16384];
  logic [7:0]  ref_m [65536];

  int checks = 0;
  int errors = 0;

  logic [15:0] oa [1:6];
  logic [3:0]  ow [1:6];
  logic [31:0] od [1:6];
  logic        any_wren;

  always #5 clk = ~clk;

  lsu_dmem_master dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req_valid    (valid),
    .o_req_ready    (ready),
    .i_req_addr     (addr),
    .i_req_we       (we),
    .i_req_size     (size),
    .i_req_unsigned (uns),
    .i_req_wdata    (wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_dmem_addr    (dm_addr),
    .o_dmem_wdata   (dm_wdata),
    .o_dmem_wren    (dm_wren),
    .i_dmem_q       (dm_q)
  );

  assign dm_q = mem[dm_addr[15:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int j = 0; j < 16384; j++) mem[j] <= 32'b0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dm_wren[b]) mem[dm_addr[15:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: rules applied directly, no word lanes.
  task automatic model(input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
    int n, off;
    logic [31:0] v;
    bit sp;
    n   = 1 << sz;
    off = int'(a[1:0]);
    sp  = (off + n) > 4;
    er  = (a[31:16] != 16'h0001) || (sz == 2'd3)
       || (sp && a[15:2] == 14'h3FFF);
    lat = (sp && !er) ? 3 : 2;
    rd  = 32'b0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++)
          ref_m[int'(a[15:0]) + i] = wd[8*i +: 8];
      end else begin
        v = 32'b0;
        for (int i = 0; i < n; i++)
          v = v | (32'(ref_m[int'(a[15:0]) + i]) << (8*i));
        if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
    int t;
    @(negedge clk);
    valid = 1'b1; addr = a; we = w; size = sz; uns = un; wdata = wd;
    t = 0;
    while (!ready && t < 10) begin @(negedge clk); t++; end
    chk("req_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0; rd = 32'b0; er = 1'b0; any_wren = 1'b0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      oa[n] = dm_addr; ow[n] = dm_wren; od[n] = dm_wdata;
      if (|dm_wren) any_wren = 1'b1;
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv [14];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, e_rd;
    logic        er, e_er;
    int          lat, e_lat;
    logic [31:0] bb_a [6];
    logic [31:0] bb_e [6];
    logic        seen;
    logic [15:0] a_hi, a_lo;
    logic [1:0]  r_sz;
    logic        r_we, r_un;
    logic [31:0] r_wd;

    tv[0]  = '{32'h0001_0008, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2};
    tv[1]  = '{32'h0001_0008, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2};
    tv[2]  = '{32'h0001_0003, 1'b1, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 2};
    tv[3]  = '{32'h0001_0003, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 2};
    tv[4]  = '{32'h0001_0003, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 2};
    tv[5]  = '{32'h0001_0006, 1'b1, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 3};
    tv[6]  = '{32'h0001_0006, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 3};
    tv[7]  = '{32'h0001_FFFF, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 2};
    tv[8]  = '{32'h0002_0000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1, 2};
    tv[9]  = '{32'h0001_0009, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00DE_AD11, 1'b0, 3};
    tv[10] = '{32'h0001_0007, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0000_2233, 1'b0, 3};
    tv[11] = '{32'h0001_000A, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0, 2};
    tv[12] = '{32'h0001_0000, 1'b1, 2'd3, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 2};
    tv[13] = '{32'h0001_000A, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0, 2};

    for (int i = 0; i < 65536; i++) ref_m[i] = 8'h00;
    valid = 1'b0; addr = 32'b0; we = 1'b0; size = 2'd0;
    uns = 1'b0; wdata = 32'b0;
    rst_n = 1'b0; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_wren", 32'(dm_wren), 32'd0);
    mem_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model(tv[i].addr, tv[i].we, tv[i].size, tv[i].uns, tv[i].wdata,
            e_rd, e_er, e_lat);
      issue(tv[i].addr, tv[i].we, tv[i].size, tv[i].uns, tv[i].wdata,
            rd, er, lat);
      chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("tv%0d_err", i), 32'(er), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d_lat", i), 32'(lat), 32'(tv[i].exp_lat));
      if (tv[i].exp_err) chk("err_no_wren", 32'(any_wren), 32'd0);
      if (i == 0) begin
        chk("sw_acc0_wren", 32'(ow[1]), 32'hF);
        chk("sw_acc0_addr", 32'(oa[1]), 32'h0008);
      end
      if (i == 2) begin
        chk("sb_wren", 32'(ow[1]), 32'h8);
        chk("sb_lane", 32'(od[1][31:24]), 32'h80);
      end
      if (i == 5) begin
        chk("split_acc0_addr", 32'(oa[1]), 32'h0004);
        chk("split_acc0_wren", 32'(ow[1]), 32'hC);
        chk("split_acc0_wdata", od[1], 32'h3344_0000);
        chk("split_acc1_addr", 32'(oa[2]), 32'h0008);
        chk("split_acc1_wren", 32'(ow[2]), 32'h3);
        chk("split_acc1_wdata", od[2], 32'h0000_1122);
      end
    end

    for (int r = 0; r < 150; r++) begin
      a_hi = ($urandom % 16 == 0) ? 16'h0003 : 16'h0001;
      a_lo = ($urandom % 8 == 0) ? 16'hFFF0 + 16'($urandom % 16)
                                 : 16'h0200 + 16'($urandom % 64);
      r_sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      r_we = 1'($urandom % 2);
      r_un = 1'($urandom % 2);
      r_wd = $urandom;
      model({a_hi, a_lo}, r_we, r_sz, r_un, r_wd, e_rd, e_er, e_lat);
      issue({a_hi, a_lo}, r_we, r_sz, r_un, r_wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", r), rd, e_rd);
      chk($sformatf("rnd%0d_err", r), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_lat", r), 32'(lat), 32'(e_lat));
      if (e_er) chk("rnd_err_no_wren", 32'(any_wren), 32'd0);
    end

    bb_a[0] = 32'h0001_0000; bb_a[1] = 32'h0001_0004;
    bb_a[2] = 32'h0001_0008; bb_a[3] = 32'h0001_000C;
    bb_a[4] = 32'h0001_0200; bb_a[5] = 32'h0001_0204;
    for (int k = 0; k < 6; k++)
      model(bb_a[k], 1'b0, 2'd2, 1'b0, 32'b0, bb_e[k], e_er, e_lat);
    @(negedge clk);
    valid = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
    for (int k = 0; k < 6; k++) begin
      addr = bb_a[k];
      chk("bb_ready_hi", 32'(ready), 32'd1);
      if (k > 0) begin
        chk("bb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk($sformatf("bb%0d_rdata", k - 1), rsp_rdata, bb_e[k - 1]);
      end
      @(posedge clk);
      @(negedge clk);
      chk("bb_ready_lo", 32'(ready), 32'd0);
      chk("bb_rsp_idle", 32'(rsp_valid), 32'd0);
      if (k == 5) valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("bb_last_valid", 32'(rsp_valid), 32'd1);
    chk("bb5_rdata", rsp_rdata, bb_e[5]);

    @(negedge clk);
    valid = 1'b1; addr = 32'h0001_0106; we = 1'b1; size = 2'd2;
    wdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("rst_split_acc0_wren", 32'(dm_wren), 32'hC);
    @(negedge clk);
    chk("rst_split_acc1_wren", 32'(dm_wren), 32'h3);
    chk("rst_split_acc1_addr", 32'(dm_addr), 32'h0108);
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", 32'(dm_wren), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_lo_word", mem[16'h0104 >> 2], 32'hCCDD_0000);
    chk("midrst_hi_word", mem[16'h0108 >> 2], 32'h0000_0000);
    ref_m[16'h0106] = 8'hDD;
    ref_m[16'h0107] = 8'hCC;
    model(32'h0001_0104, 1'b0, 2'd2, 1'b0, 32'b0, e_rd, e_er, e_lat);
    issue(32'h0001_0104, 1'b0, 2'd2, 1'b0, 32'b0, rd, er, lat);
    chk("post_rst_lw", rd, e_rd);
    chk("post_rst_lat", 32'(lat), 32'(e_lat));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
